// File: rtl/target_net_weight_sync_if.sv
// Weight-side bus of the target-network sync block.
// The master side (the sync block) streams reads from the main-net weight RAM
// and issues single-word writes into the target-net weight memory.
//   o_src_ram_enable / o_src_rw_select / o_src_layer : main-net RAM read request
//   i_src_weight / i_src_valid                       : main-net RAM read return
//   o_dst_ram_enable / o_dst_rw_select / o_dst_layer
//   / o_dst_weight                                   : target-net RAM write
interface target_net_weight_sync_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LAYER_WIDTH = 2
);
    logic                   o_src_ram_enable;
    logic                   o_src_rw_select;
    logic [LAYER_WIDTH-1:0] o_src_layer;
    logic [DATA_WIDTH-1:0]  i_src_weight;
    logic                   i_src_valid;
    logic                   o_dst_ram_enable;
    logic                   o_dst_rw_select;
    logic [LAYER_WIDTH-1:0] o_dst_layer;
    logic [DATA_WIDTH-1:0]  o_dst_weight;

    modport master (
        output o_src_ram_enable, o_src_rw_select, o_src_layer,
        input  i_src_weight, i_src_valid,
        output o_dst_ram_enable, o_dst_rw_select, o_dst_layer, o_dst_weight
    );

    modport slave (
        input  o_src_ram_enable, o_src_rw_select, o_src_layer,
        output i_src_weight, i_src_valid,
        input  o_dst_ram_enable, o_dst_rw_select, o_dst_layer, o_dst_weight
    );
endinterface

// File: rtl/target_net_weight_sync.sv
// DQN target-network update sequencer: copies every weight of the main
// (policy) net into the target net, layer by layer, as a streamed
// read/write transfer. Takes the target weight RAM only while the target
// inference path is idle and holds a lock until the copy completes.
//   clk, rst        : clock, synchronous active-high reset
//   i_start         : request a full copy (sampled in IDLE only)
//   i_target_busy   : target inference path is using the target RAM
//   o_target_lock   : this block owns the target RAM
//   o_busy / o_done : copy in progress / one-cycle completion pulse
//   o_overrun       : sticky, source returned more words than requested
//   bus             : main-net read port and target-net write port
module target_net_weight_sync #(
    parameter int unsigned DATA_WIDTH                    = 32,
    parameter int unsigned LAYER_WIDTH                   = 2,
    parameter int unsigned NUMBER_OF_INPUT_NODE          = 2,
    parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int unsigned NUMBER_OF_OUTPUT_NODE         = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_target_busy,
    output logic                     o_target_lock,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_overrun,
    target_net_weight_sync_if.master bus
);
    // Words per layer, bias weights included.
    localparam int unsigned N0    = (NUMBER_OF_INPUT_NODE + 1) * NUMBER_OF_HIDDEN_NODE_LAYER_1;
    localparam int unsigned N1    = (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1) * NUMBER_OF_HIDDEN_NODE_LAYER_2;
    localparam int unsigned N2    = (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1) * NUMBER_OF_OUTPUT_NODE;
    localparam int unsigned N01   = (N0 > N1) ? N0 : N1;
    localparam int unsigned N_MAX = (N01 > N2) ? N01 : N2;
    localparam int unsigned CNT_W = $clog2(N_MAX + 1);

    localparam logic [LAYER_WIDTH-1:0] LAST_LAYER = LAYER_WIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FREE,
        S_READ,
        S_DRAIN,
        S_GAP,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [LAYER_WIDTH-1:0] layer;
    logic [LAYER_WIDTH-1:0] layer_nxt;
    logic [CNT_W-1:0]       issue_cnt;
    logic [CNT_W-1:0]       rcv_cnt;
    logic [CNT_W-1:0]       n_cur_c;
    logic                   rcv_active_c;
    logic                   accept_c;
    logic                   drop_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, layer sequencing and receive-path qualification.
    always_comb begin
        state_nxt    = state;
        layer_nxt    = layer;
        n_cur_c      = CNT_W'(N2);
        rcv_active_c = 1'b0;
        accept_c     = 1'b0;
        drop_c       = 1'b0;

        if (layer == LAYER_WIDTH'(0)) begin
            n_cur_c = CNT_W'(N0);
        end else if (layer == LAYER_WIDTH'(1)) begin
            n_cur_c = CNT_W'(N1);
        end

        // Words beyond the layer count are dropped and flagged, never written.
        rcv_active_c = (state == S_READ) || (state == S_DRAIN);
        accept_c     = rcv_active_c && bus.i_src_valid && (rcv_cnt != n_cur_c);
        drop_c       = rcv_active_c && bus.i_src_valid && (rcv_cnt == n_cur_c);

        unique case (state)
            S_IDLE:      if (i_start) state_nxt = S_WAIT_FREE;
            S_WAIT_FREE: if (!i_target_busy) state_nxt = S_READ;
            S_READ:      if (issue_cnt == n_cur_c - CNT_W'(1)) state_nxt = S_DRAIN;
            S_DRAIN:     if (rcv_cnt == n_cur_c) state_nxt = S_GAP;
            S_GAP:       state_nxt = (layer == LAST_LAYER) ? S_DONE : S_READ;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase

        if ((state_nxt == S_IDLE) || (state == S_WAIT_FREE)) begin
            layer_nxt = '0;
        end else if ((state == S_GAP) && (state_nxt == S_READ)) begin
            layer_nxt = layer + LAYER_WIDTH'(1);
        end
    end

    // Registered outputs, counters and layer; all decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            layer                <= '0;
            issue_cnt            <= '0;
            rcv_cnt              <= '0;
            o_target_lock        <= 1'b0;
            o_busy               <= 1'b0;
            o_done               <= 1'b0;
            o_overrun            <= 1'b0;
            bus.o_src_ram_enable <= 1'b0;
            bus.o_src_rw_select  <= 1'b0;
            bus.o_src_layer      <= '0;
            bus.o_dst_ram_enable <= 1'b0;
            bus.o_dst_rw_select  <= 1'b0;
            bus.o_dst_layer      <= '0;
            bus.o_dst_weight     <= '0;
        end else begin
            layer         <= layer_nxt;
            o_busy        <= (state_nxt != S_IDLE);
            o_target_lock <= (state_nxt == S_READ) || (state_nxt == S_DRAIN) ||
                             (state_nxt == S_GAP)  || (state_nxt == S_DONE);
            o_done        <= (state_nxt == S_DONE);

            bus.o_src_ram_enable <= (state_nxt == S_READ);
            bus.o_src_rw_select  <= (state_nxt == S_READ);
            bus.o_src_layer      <= (state_nxt == S_READ) ? layer_nxt : '0;

            bus.o_dst_ram_enable <= accept_c;
            bus.o_dst_rw_select  <= 1'b0;
            bus.o_dst_layer      <= accept_c ? layer : '0;
            bus.o_dst_weight     <= accept_c ? bus.i_src_weight : '0;

            if ((state == S_IDLE) && i_start) begin
                o_overrun <= 1'b0;
            end else if (drop_c) begin
                o_overrun <= 1'b1;
            end

            // The GAP cycle lets the streaming RAMs restart their pointers.
            if ((state_nxt == S_GAP) || (state_nxt == S_IDLE)) begin
                issue_cnt <= '0;
                rcv_cnt   <= '0;
            end else begin
                if (state == S_READ) issue_cnt <= issue_cnt + CNT_W'(1);
                if (accept_c)        rcv_cnt   <= rcv_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_target_net_weight_sync.sv
// Self-checking bench for target_net_weight_sync: a small configuration
// driven by a queued source model with latency/bubble/extra-word knobs, and
// the default configuration driven by a continuous source.
module tb_target_net_weight_sync;
    localparam int unsigned S_IN = 2, S_H1 = 2, S_H2 = 2, S_OUT = 1;
    localparam int S_N0 = (S_IN + 1) * S_H1;
    localparam int S_N1 = (S_H1 + 1) * S_H2;
    localparam int S_N2 = (S_H2 + 1) * S_OUT;
    localparam int S_TOTAL = S_N0 + S_N1 + S_N2;
    localparam int D_N0 = 3 * 32, D_N1 = 33 * 32, D_N2 = 33 * 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- small configuration DUT ----------------
    target_net_weight_sync_if #(.DATA_WIDTH(32), .LAYER_WIDTH(2)) sbus ();
    logic s_start, s_tbusy, s_lock, s_busy, s_done, s_overrun;

    target_net_weight_sync #(
        .DATA_WIDTH(32), .LAYER_WIDTH(2),
        .NUMBER_OF_INPUT_NODE(S_IN), .NUMBER_OF_HIDDEN_NODE_LAYER_1(S_H1),
        .NUMBER_OF_HIDDEN_NODE_LAYER_2(S_H2), .NUMBER_OF_OUTPUT_NODE(S_OUT)
    ) dut_s (
        .clk(clk), .rst(rst), .i_start(s_start), .i_target_busy(s_tbusy),
        .o_target_lock(s_lock), .o_busy(s_busy), .o_done(s_done),
        .o_overrun(s_overrun), .bus(sbus)
    );

    // ---------------- default configuration DUT ----------------
    target_net_weight_sync_if #(.DATA_WIDTH(32), .LAYER_WIDTH(2)) dbus ();
    logic d_start, d_tbusy, d_lock, d_busy, d_done, d_overrun;

    target_net_weight_sync dut_d (
        .clk(clk), .rst(rst), .i_start(d_start), .i_target_busy(d_tbusy),
        .o_target_lock(d_lock), .o_busy(d_busy), .o_done(d_done),
        .o_overrun(d_overrun), .bus(dbus)
    );

    // ---------------- small-config source model and monitors ----------------
    typedef struct { logic [31:0] data; int ready; } pend_t;
    typedef struct { logic [31:0] data; int vcyc; } fly_t;

    pend_t       pend_q[$];
    fly_t        fly_q[$];
    logic [31:0] exp_q[$];
    int          en_widths[$];
    int          idx_l[3];
    int          src_lat = 2, src_bub = 0, src_extra = 0;
    int          gap_left = 0, extra_left = 0, en_run = 0;
    int          wr_count = 0, done_count = 0, last_wr_cyc = 0;
    bit          after_done = 0, cur_exp_ovr = 0, src_on = 0;

    always @(negedge clk) begin
        pend_t p;
        fly_t  f;
        logic [31:0] e;
        sbus.i_src_valid  = 1'b0;
        sbus.i_src_weight = 32'h0;
        if (src_on) begin
            if (extra_left > 0) begin
                sbus.i_src_valid  = 1'b1;
                sbus.i_src_weight = 32'hDEAD_BEEF;
                extra_left--;
            end else if (gap_left > 0) begin
                gap_left--;
            end else if (pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
                p = pend_q.pop_front();
                sbus.i_src_valid  = 1'b1;
                sbus.i_src_weight = p.data;
                fly_q.push_back('{p.data, cyc});
                gap_left = (src_bub > 0) ? int'($urandom_range(0, src_bub)) : 0;
                if (src_extra > 0 && p.data == 32'(256 + S_N1 - 1)) extra_left = src_extra;
            end
            if (sbus.o_src_ram_enable) begin
                pend_q.push_back('{32'(int'(sbus.o_src_layer) * 256 + idx_l[sbus.o_src_layer]), cyc + src_lat});
                idx_l[sbus.o_src_layer]++;
            end
        end

        if (sbus.o_src_ram_enable) en_run++;
        else if (en_run > 0) begin
            en_widths.push_back(en_run);
            en_run = 0;
        end

        if (sbus.o_dst_ram_enable) begin
            wr_count++;
            last_wr_cyc = cyc;
            if (fly_q.size() == 0 || exp_q.size() == 0) begin
                check("unexpected_write", longint'(sbus.o_dst_weight), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                f = fly_q.pop_front();
                e = exp_q.pop_front();
                check("wr_data", longint'(sbus.o_dst_weight), longint'(e));
                check("wr_layer", longint'(sbus.o_dst_layer), longint'(e >> 8));
                check("wr_latency", longint'(cyc), longint'(f.vcyc + 1));
                check("wr_rw_select", longint'(sbus.o_dst_rw_select), 0);
            end
        end

        if (after_done) begin
            check("busy_after_done", longint'(s_busy), 0);
            check("lock_after_done", longint'(s_lock), 0);
            check("done_one_cycle", longint'(s_done), 0);
            after_done = 0;
        end
        if (s_done) begin
            done_count++;
            after_done = 1;
            check("done_after_last_write", longint'(wr_count), S_TOTAL);
            check("done_after_write_cycle", longint'(cyc > last_wr_cyc), 1);
            check("lock_at_done", longint'(s_lock), 1);
            check("overrun_at_done", longint'(s_overrun), longint'(cur_exp_ovr));
        end
    end

    // ---------------- default-config continuous source and monitor ----------------
    bit          d_pend_v = 0;
    logic [31:0] d_pend_d = 0;
    logic [31:0] d_seq = 0, d_wr_exp = 0;
    int          d_wr = 0, d_bad = 0, d_done_cnt = 0, d_done_cyc = 0;
    int          d_wr_layer[4];

    always @(negedge clk) begin
        dbus.i_src_valid  = d_pend_v;
        dbus.i_src_weight = d_pend_d;
        d_pend_v = dbus.o_src_ram_enable;
        if (d_pend_v) begin
            d_pend_d = d_seq;
            d_seq++;
        end
        if (dbus.o_dst_ram_enable) begin
            d_wr++;
            d_wr_layer[dbus.o_dst_layer]++;
            if (dbus.o_dst_weight != d_wr_exp) d_bad++;
            d_wr_exp++;
        end
        if (d_done) begin
            d_done_cnt++;
            d_done_cyc = cyc;
        end
    end

    // ---------------- helpers ----------------
    task automatic prep(input int lat, input int bub, input int extra, input bit exp_ovr);
        src_lat = lat; src_bub = bub; src_extra = extra; cur_exp_ovr = exp_ovr;
        gap_left = 0; extra_left = 0;
        pend_q.delete(); fly_q.delete(); exp_q.delete(); en_widths.delete();
        for (int l = 0; l < 3; l++) idx_l[l] = 0;
        // Reference: every layer in order, words 0..N-1, data = {layer, index}.
        for (int i = 0; i < S_N0; i++) exp_q.push_back(32'(i));
        for (int i = 0; i < S_N1; i++) exp_q.push_back(32'(256 + i));
        for (int i = 0; i < S_N2; i++) exp_q.push_back(32'(512 + i));
        wr_count = 0; done_count = 0;
    endtask

    task automatic pulse_start();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_count == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_count == 0) check(name, 0, 1);
        repeat (3) tick();
    endtask

    task automatic check_run(input string tag);
        check({tag, "_writes"}, longint'(wr_count), S_TOTAL);
        check({tag, "_done_pulses"}, longint'(done_count), 1);
        check({tag, "_overrun"}, longint'(s_overrun), longint'(cur_exp_ovr));
        check({tag, "_en_runs"}, longint'(en_widths.size()), 3);
        if (en_widths.size() == 3) begin
            check({tag, "_en_w0"}, longint'(en_widths[0]), S_N0);
            check({tag, "_en_w1"}, longint'(en_widths[1]), S_N1);
            check({tag, "_en_w2"}, longint'(en_widths[2]), S_N2);
        end
    endtask

    typedef struct {
        int lat;
        int bub;
        int extra;
        bit exp_overrun;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int n;
        vecs[0] = '{2, 0, 0, 1'b0};
        vecs[1] = '{2, 5, 0, 1'b0};
        vecs[2] = '{2, 0, 2, 1'b1};
        vecs[3] = '{1, 0, 0, 1'b0};
        vecs[4] = '{3, 3, 0, 1'b0};

        rst = 1'b1;
        s_start = 1'b0; s_tbusy = 1'b0;
        d_start = 1'b0; d_tbusy = 1'b0;
        for (int l = 0; l < 4; l++) d_wr_layer[l] = 0;
        repeat (3) tick();
        check("reset_outputs_small",
              longint'({s_lock, s_busy, s_done, s_overrun, sbus.o_src_ram_enable,
                        sbus.o_src_rw_select, sbus.o_src_layer, sbus.o_dst_ram_enable,
                        sbus.o_dst_layer, sbus.o_dst_weight}), 0);
        check("reset_outputs_default",
              longint'({d_lock, d_busy, d_done, d_overrun, dbus.o_src_ram_enable,
                        dbus.o_dst_ram_enable, dbus.o_dst_weight}), 0);
        rst = 1'b0;
        src_on = 1;
        tick();

        // Table of source behaviours, each a full copy.
        for (int i = 0; i < 5; i++) begin
            prep(vecs[i].lat, vecs[i].bub, vecs[i].extra, vecs[i].exp_overrun);
            if (i > 0) check("overrun_held_idle", longint'(s_overrun), longint'(vecs[i-1].exp_overrun));
            pulse_start();
            check("busy_after_start", longint'(s_busy), 1);
            check("overrun_cleared_on_start", longint'(s_overrun), 0);
            wait_done("timeout_table_run", 600);
            check_run($sformatf("vec%0d", i));
        end

        // Start while the inference path holds the target RAM.
        prep(2, 0, 0, 1'b0);
        s_tbusy = 1'b1;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            check("wait_free_no_src_en", longint'(sbus.o_src_ram_enable), 0);
            check("wait_free_no_lock", longint'(s_lock), 0);
            if (i == 9) s_tbusy = 1'b0;
            tick();
        end
        check("lock_after_busy_falls", longint'(s_lock), 1);
        check("read_after_busy_falls", longint'(sbus.o_src_ram_enable), 1);
        check("read_starts_layer0", longint'(sbus.o_src_layer), 0);
        wait_done("timeout_busy_run", 600);
        check_run("busy");

        // Start ignored while a copy is running.
        prep(2, 0, 0, 1'b0);
        pulse_start();
        repeat (4) tick();
        pulse_start();
        wait_done("timeout_restart_run", 600);
        check_run("restart_ignored");
        repeat (5) tick();
        check("no_queued_start", longint'(s_busy), 0);

        // Reset in the middle of layer 1 READ.
        prep(2, 0, 0, 1'b0);
        pulse_start();
        n = 0;
        while (!(sbus.o_src_ram_enable && sbus.o_src_layer == 2'd1) && n < 200) begin
            tick();
            n++;
        end
        check("reached_layer1_read", longint'(n < 200), 1);
        rst = 1'b1;
        tick();
        check("midcopy_reset_outputs",
              longint'({s_lock, s_busy, s_done, s_overrun, sbus.o_src_ram_enable,
                        sbus.o_src_rw_select, sbus.o_src_layer, sbus.o_dst_ram_enable,
                        sbus.o_dst_layer, sbus.o_dst_weight}), 0);
        rst = 1'b0;
        exp_q.delete();
        fly_q.delete();
        n = wr_count;
        repeat (10) tick();
        check("no_writes_after_reset", longint'(wr_count), longint'(n));
        check("idle_after_reset", longint'(s_busy), 0);
        prep(2, 0, 0, 1'b0);
        pulse_start();
        wait_done("timeout_post_reset_run", 600);
        check_run("post_reset");

        // Default configuration, continuous source.
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        n = cyc;
        while (d_done_cnt == 0 && cyc - n < 3000) tick();
        check("default_done_seen", longint'(d_done_cnt), 1);
        repeat (3) tick();
        check("default_total_writes", longint'(d_wr), D_N0 + D_N1 + D_N2);
        check("default_layer0_writes", longint'(d_wr_layer[0]), D_N0);
        check("default_layer1_writes", longint'(d_wr_layer[1]), D_N1);
        check("default_layer2_writes", longint'(d_wr_layer[2]), D_N2);
        check("default_data_order_errors", longint'(d_bad), 0);
        check("default_no_overrun", longint'(d_overrun), 0);
        check("default_done_pulses", longint'(d_done_cnt), 1);
        check("default_done_timing",
              longint'((d_done_cyc - n) >= (D_N0 + D_N1 + D_N2 + 3) &&
                       (d_done_cyc - n) <= (D_N0 + D_N1 + D_N2 + 3 + 16)), 1);
        check("default_idle_after_done", longint'({d_busy, d_lock}), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
